// File: rtl/trig_arb_pkg.sv
// Shared constants and types for the trig ROM arbiter and its users.
package trig_arb_pkg;

   localparam int NUM_REQ_D = 4;
   localparam int ANGLE_W_D = 6;
   localparam int VEC_W_D   = 8;

   // Requester id width; a lone requester still needs one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic        [ANGLE_W_D-1:0] angle_t;
   typedef logic signed [VEC_W_D-1:0]   vec_t;

endpackage

// File: rtl/trig_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] id
);

   always_comb begin
      logic found;
      // NOTE: every output gets a default first so no path leaves a latch.
      grant = '0;
      id    = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            id         = ID_W'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trig_rom_arbiter.sv
// Round-robin sharing of one sin/cos ROM pair among NUM_REQ motion requesters,
// one lookup per cycle, results returned with a one-hot strobe to the owner.
module trig_rom_arbiter
   import trig_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_D,
   parameter int ANGLE_W = ANGLE_W_D,
   parameter int VEC_W   = VEC_W_D,
   parameter int ROM_LAT = 0
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ANGLE_W-1:0] angle_in,
   output logic [NUM_REQ-1:0]         grant,
   output logic [ANGLE_W-1:0]         rom_addr,
   input  logic [VEC_W-1:0]           rom_cos,
   input  logic [VEC_W-1:0]           rom_sin,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [VEC_W-1:0]           cos_out,
   output logic [VEC_W-1:0]           sin_out
);

   localparam int ID_W = id_w(NUM_REQ);

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_next;
   logic [ID_W-1:0]    pick_id;
   logic [NUM_REQ-1:0] pick_grant;
   logic               accept;

   // Valid/tag travel beside the ROM; stage ROM_LAT lines up with ROM data.
   logic [ROM_LAT:0]   pipe_vld;
   logic [ID_W-1:0]    pipe_tag [ROM_LAT:0];

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .id    (pick_id)
   );

   // Held-off grant during Reset keeps requesters from dropping a request.
   assign grant    = Reset ? '0 : pick_grant;
   assign accept   = |grant;
   assign ptr_next = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr      <= '0;
         rom_addr <= '0;
         pipe_vld <= '0;
         // NOTE: tag stages are reset too so no stale id can surface after Reset.
         for (int k = 0; k <= ROM_LAT; k++) pipe_tag[k] <= '0;
      end else begin
         // NOTE: non-blocking so every stage shifts from the pre-edge values.
         pipe_vld[0] <= accept;
         for (int k = 1; k <= ROM_LAT; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_tag[k] <= pipe_tag[k-1];
         end
         if (accept) begin
            rom_addr    <= angle_in[int'(pick_id)*ANGLE_W +: ANGLE_W];
            pipe_tag[0] <= pick_id;
            ptr         <= ptr_next;
         end
      end
   end

   // Response stage: capture ROM data and strobe the owner for one cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rsp_valid <= '0;
         cos_out   <= '0;
         sin_out   <= '0;
      end else begin
         rsp_valid <= '0;
         if (pipe_vld[ROM_LAT]) begin
            rsp_valid <= NUM_REQ'(1) << pipe_tag[ROM_LAT];
            cos_out   <= rom_cos;
            sin_out   <= rom_sin;
         end
      end
   end

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Bench: one combinational-ROM and one two-stage-ROM arbiter on shared stimulus,
// each with a response scoreboard drained by its own monitor.
module tb_trig_rom_arbiter;
   import trig_arb_pkg::*;

   typedef struct {
      logic [3:0] rv;
      logic [7:0] c;
      logic [7:0] s;
      int         due;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [23:0] angle_in;

   logic [3:0]  g0, g2, rv0, rv2;
   logic [5:0]  ra0, ra2;
   logic [7:0]  rc0, rs0, rc2, rs2, co0, so0, co2, so2;
   angle_t      a1, a2;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   mptr   = 0;
   rsp_t q0[$];
   rsp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] cos_f(input angle_t a);
      return {2'b00, a};
   endfunction

   function automatic logic [7:0] sin_f(input angle_t a);
      return ~{2'b00, a};
   endfunction

   function automatic logic [23:0] pk(input int x0, input int x1, input int x2, input int x3);
      return {6'(x3), 6'(x2), 6'(x1), 6'(x0)};
   endfunction

   function automatic logic [3:0] rr_exp(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (p + k) % 4;
         if (r[i]) return 4'(1 << i);
      end
      return 4'b0000;
   endfunction

   // Model ROMs: combinational for the latency-0 unit, two registers for the other.
   assign rc0 = cos_f(ra0);
   assign rs0 = sin_f(ra0);
   always @(posedge clk) begin
      a1 <= ra2;
      a2 <= a1;
   end
   assign rc2 = cos_f(a2);
   assign rs2 = sin_f(a2);

   trig_rom_arbiter #(.NUM_REQ(4), .ANGLE_W(6), .VEC_W(8), .ROM_LAT(0)) dut0 (
      .Clk(clk), .Reset(rst), .req(req), .angle_in(angle_in), .grant(g0),
      .rom_addr(ra0), .rom_cos(rc0), .rom_sin(rs0), .rsp_valid(rv0),
      .cos_out(co0), .sin_out(so0)
   );

   trig_rom_arbiter #(.NUM_REQ(4), .ANGLE_W(6), .VEC_W(8), .ROM_LAT(2)) dut2 (
      .Clk(clk), .Reset(rst), .req(req), .angle_in(angle_in), .grant(g2),
      .rom_addr(ra2), .rom_cos(rc2), .rom_sin(rs2), .rsp_valid(rv2),
      .cos_out(co2), .sin_out(so2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic judge(input string nm, input logic [3:0] rv, input logic [7:0] c,
                        input logic [7:0] s, input rsp_t e);
      check({nm, "_rsp_valid"}, rv, e.rv);
      check({nm, "_cos"}, c, e.c);
      check({nm, "_sin"}, s, e.s);
      check({nm, "_latency"}, cyc, e.due);
   endtask

   // Drive one cycle of requests, check the grant, and log what must come back.
   task automatic step(input logic [3:0] r, input logic [23:0] ang, input logic [3:0] exp_g);
      rsp_t e;
      int   id;
      @(negedge clk);
      req      = r;
      angle_in = ang;
      #1;
      check("grant_lat0", g0, exp_g);
      check("grant_lat2", g2, exp_g);
      if (exp_g != 4'b0000) begin
         id = 0;
         for (int i = 0; i < 4; i++) if (exp_g[i]) id = i;
         e.rv  = exp_g;
         e.c   = cos_f(ang[id*6 +: 6]);
         e.s   = sin_f(ang[id*6 +: 6]);
         e.due = cyc + 2;
         q0.push_back(e);
         e.due = cyc + 4;
         q2.push_back(e);
         mptr = (id + 1) % 4;
      end
   endtask

   always @(posedge clk) begin
      rsp_t e;
      #1;
      if (rv0 != 4'b0000 || (q0.size() != 0 && q0[0].due <= cyc)) begin
         if (q0.size() == 0) check("spurious_lat0", rv0, 0);
         else begin
            e = q0.pop_front();
            judge("lat0", rv0, co0, so0, e);
         end
      end
      if (rv2 != 4'b0000 || (q2.size() != 0 && q2[0].due <= cyc)) begin
         if (q2.size() == 0) check("spurious_lat2", rv2, 0);
         else begin
            e = q2.pop_front();
            judge("lat2", rv2, co2, so2, e);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  r, last_g, eg;
      logic [23:0] ang;

      rst      = 1'b1;
      req      = 4'b0000;
      angle_in = '0;
      repeat (2) @(negedge clk);
      req = 4'b1111;
      #1;
      check("reset_grant_lat0", g0, 4'b0000);
      check("reset_grant_lat2", g2, 4'b0000);
      check("reset_rsp_valid", rv0, 4'b0000);
      check("reset_cos_out", co0, 8'h00);
      check("reset_sin_out", so0, 8'h00);
      check("reset_rom_addr", ra2, 6'd0);
      req = 4'b0000;
      #1 rst = 1'b0;

      // All requesters busy: strict rotation, one response per cycle.
      for (int n = 0; n < 8; n++) step(4'b1111, pk(3, 7, 11, 15), 4'(1 << (n % 4)));

      // Lone requester 1 with angle 16.
      step(4'b0010, pk(0, 16, 0, 0), 4'b0010);
      @(posedge clk);
      #1;
      check("rom_addr_lat0", ra0, 6'd16);
      check("rom_addr_lat2", ra2, 6'd16);

      // Pointer at 2, requester 2 idle: it must be skipped.
      step(4'b1011, pk(20, 21, 0, 23), 4'b1000);
      step(4'b1011, pk(20, 21, 0, 23), 4'b0001);
      step(4'b1011, pk(20, 21, 0, 23), 4'b0010);

      // Idle: outputs hold, pointer holds.
      repeat (5) step(4'b0000, '0, 4'b0000);
      check("hold_cos_lat0", co0, 8'h15);
      check("hold_sin_lat0", so0, 8'hEA);
      check("hold_cos_lat2", co2, 8'h15);
      check("hold_sin_lat2", so2, 8'hEA);
      check("idle_rsp_lat0", rv0, 4'b0000);
      check("idle_rsp_lat2", rv2, 4'b0000);
      step(4'b1111, pk(1, 2, 3, 4), 4'b0100);
      step(4'b0001, pk(5, 0, 0, 0), 4'b0001);
      step(4'b0010, pk(0, 9, 0, 0), 4'b0010);

      // Asynchronous reset mid-cycle with lookups in flight.
      @(negedge clk);
      req = 4'b1111;
      #2 rst = 1'b1;
      #1;
      check("midreset_rsp_lat0", rv0, 4'b0000);
      check("midreset_rsp_lat2", rv2, 4'b0000);
      check("midreset_grant_lat0", g0, 4'b0000);
      check("midreset_grant_lat2", g2, 4'b0000);
      q0.delete();
      q2.delete();
      mptr = 0;
      req  = 4'b0000;
      #1 rst = 1'b0;
      repeat (4) step(4'b0000, '0, 4'b0000);
      step(4'b1111, pk(1, 2, 3, 4), 4'b0001);

      // Randomised traffic honouring the hold-until-granted contract.
      r      = 4'b0000;
      ang    = '0;
      last_g = 4'b0001;
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!r[i] || last_g[i]) begin
               r[i]         = ($urandom_range(0, 2) != 0);
               ang[i*6 +: 6] = 6'($urandom);
            end
         end
         eg = rr_exp(r, mptr);
         step(r, ang, eg);
         last_g = eg;
      end

      repeat (6) step(4'b0000, '0, 4'b0000);
      check("drained_lat0", q0.size(), 0);
      check("drained_lat2", q2.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
